icache_dm_param: RTL and testbench

//  Parametrised direct-mapped instruction cache between the PC stage and IF/ID.
//  Hit: returns the 32-bit word one cycle after lookup. Miss: sends one 48-bit request to the

---
 rtl/icache_dm_param.sv | 163 ++++++++++++++++
 tb/tb_icache_dm_param.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/icache_dm_param.sv
// Direct-mapped instruction cache between the PC stage and IF/ID. Each set holds
// {valid, tag} and one line. Misses send a single request and forward the word from the refill bus.
module icache_dm_param #(
  parameter int          WORDS_PER_LINE = 4,
  parameter int          INDEX_W        = 5,
  parameter int          HOME_LSB       = 11,
  parameter logic [1:0]  LOCAL_ID       = 2'b00,
  parameter logic [4:0]  CMD_INSTREQ    = 5'b00110
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         v_pc,
  input  logic [31:0]                  pc,
  output logic                         pc_ready,
  output logic                         v_inst,
  output logic [31:0]                  inst,
  output logic                         v_ic_req,
  input  logic                         ic_req_ready,
  output logic                         local_or_OUT,
  output logic [47:0]                  req_msg,
  input  logic                         v_refill,
  input  logic [32*WORDS_PER_LINE-1:0] refill_data,
  input  logic                         flush
);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE) + 2;
  localparam int SETS   = 2**INDEX_W;
  localparam int TAG_W  = 32 - INDEX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;

  typedef enum logic [2:0] {S_SWEEP, S_IDLE, S_LOOKUP, S_REQ, S_WAIT} state_t;

  typedef struct packed {
    logic [1:0]  home;
    logic        one;
    logic [1:0]  src;
    logic        zero;
    logic [4:0]  cmd;
    logic [4:0]  pad;
    logic [31:0] addr;
  } req_t;

  state_t                   state, state_n;
  logic [INDEX_W-1:0]       sweep_cnt;
  logic                     flush_pend, flush_clr;
  logic [31:0]              pc_q;
  logic                     v_inst_q;
  logic [31:0]              inst_q;

  logic                     pc_accept, hit, fill_now;
  logic                     tag_we, data_we;
  logic [INDEX_W-1:0]       tag_wa;
  logic [TAG_W:0]           tag_wd, tag_rd;
  logic [TAG_W:0]           tag_mem [SETS];

  logic [WORDS_PER_LINE-1:0][31:0] data_rd, refill_w;

  wire [INDEX_W-1:0] idx_in = pc[INDEX_W+OFF_W-1:OFF_W];
  wire [INDEX_W-1:0] idx_q  = pc_q[INDEX_W+OFF_W-1:OFF_W];
  wire [TAG_W-1:0]   tag_q  = pc_q[31:32-TAG_W];
  wire [WSEL_W-1:0]  wsel   = pc_q[OFF_W-1:2];
  wire [1:0]         home   = pc_q[HOME_LSB+1:HOME_LSB];

  assign refill_w = refill_data;
  assign hit      = tag_rd[TAG_W] && (tag_rd[TAG_W-1:0] == tag_q);
  assign fill_now = (state == S_WAIT) && v_refill;

  always_comb begin
    state_n   = state;
    pc_accept = 1'b0;
    flush_clr = 1'b0;
    tag_we    = 1'b0;
    tag_wa    = idx_q;
    tag_wd    = '0;
    data_we   = 1'b0;
    case (state)
      S_SWEEP: begin
        tag_we = 1'b1;
        tag_wa = sweep_cnt;
        if (sweep_cnt == INDEX_W'(SETS-1)) state_n = S_IDLE;
      end
      S_IDLE: begin
        // a pending flush wins over a waiting fetch, which stays un-accepted
        if (flush_pend) begin
          flush_clr = 1'b1;
          state_n   = S_SWEEP;
        end else if (v_pc) begin
          pc_accept = 1'b1;
          state_n   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) state_n = S_IDLE;
        else begin
          tag_we  = 1'b1;
          tag_wd  = {1'b0, tag_q};
          state_n = S_REQ;
        end
      end
      S_REQ: if (ic_req_ready) state_n = S_WAIT;
      S_WAIT: begin
        if (v_refill) begin
          tag_we  = 1'b1;
          tag_wd  = {1'b1, tag_q};
          data_we = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_SWEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_SWEEP;
      sweep_cnt  <= '0;
      flush_pend <= 1'b0;
      pc_q       <= '0;
      v_inst_q   <= 1'b0;
      inst_q     <= '0;
    end else begin
      state      <= state_n;
      sweep_cnt  <= (state == S_SWEEP) ? sweep_cnt + 1'b1 : '0;
      flush_pend <= flush | (flush_pend & ~flush_clr);
      if (pc_accept) pc_q <= pc;
      v_inst_q   <= (state == S_LOOKUP) && hit;
      inst_q     <= ((state == S_LOOKUP) && hit) ? data_rd[wsel] : '0;
    end
  end

  // Array accesses never overlap: reads only in IDLE, writes only in SWEEP/LOOKUP/WAIT.
  always_ff @(posedge clk) begin
    if (tag_we)    tag_mem[tag_wa] <= tag_wd;
    if (pc_accept) tag_rd <= tag_mem[idx_in];
  end

  for (genvar w = 0; w < WORDS_PER_LINE; w++) begin : g_bank
    logic [31:0] bank [SETS];
    logic [31:0] rd;
    always_ff @(posedge clk) begin
      if (data_we)   bank[idx_q] <= refill_w[w];
      if (pc_accept) rd <= bank[idx_in];
    end
    assign data_rd[w] = rd;
  end

  req_t msg;
  always_comb begin
    msg.home = home;
    msg.one  = 1'b1;
    msg.src  = LOCAL_ID;
    msg.zero = 1'b0;
    msg.cmd  = CMD_INSTREQ;
    msg.pad  = '0;
    msg.addr = pc_q;
  end

  assign pc_ready     = (state == S_IDLE) && !flush_pend;
  assign v_ic_req     = (state == S_REQ);
  assign req_msg      = v_ic_req ? msg : '0;
  assign local_or_OUT = v_ic_req && (home == LOCAL_ID);
  assign v_inst       = v_inst_q | fill_now;
  assign inst         = fill_now ? refill_w[wsel] : inst_q;
endmodule

// File: tb/tb_icache_dm_param.sv
// Scoreboard bench for icache_dm_param: a set/tag model predicts hits, misses,
// request messages and delivered words; a negedge monitor pops and compares.
module tb_icache_dm_param;
  localparam int SETS = 32;

  logic         clk = 1'b0, rst = 1'b1;
  logic         v_pc = 1'b0, ic_req_ready = 1'b0, v_refill = 1'b0, flush = 1'b0;
  logic [31:0]  pc = '0;
  logic [127:0] refill_data = '0;
  logic         pc_ready, v_inst, v_ic_req, local_or_OUT;
  logic [31:0]  inst;
  logic [47:0]  req_msg;

  icache_dm_param dut (
    .clk(clk), .rst(rst), .v_pc(v_pc), .pc(pc), .pc_ready(pc_ready),
    .v_inst(v_inst), .inst(inst), .v_ic_req(v_ic_req), .ic_req_ready(ic_req_ready),
    .local_or_OUT(local_or_OUT), .req_msg(req_msg), .v_refill(v_refill),
    .refill_data(refill_data), .flush(flush)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [31:0] exp_inst [$];
  logic [48:0] exp_req  [$];

  // behavioural cache contents and backing memory
  bit          m_valid [SETS];
  logic [22:0] m_tag   [SETS];
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [47:0] exp_msg(input logic [31:0] a);
    return {a[12:11], 1'b1, 2'b00, 1'b0, 5'b00110, 5'b00000, a};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic invalidate_all();
    for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
  endtask

  // hold < 0 picks a random request back-pressure length
  task automatic fetch(input logic [31:0] a, input int hold, input bit flush_in_wait);
    int s, n, d;
    logic [22:0]  tg;
    bit           hit;
    logic [47:0]  m;
    logic [127:0] line;
    s   = int'(a[8:4]);
    tg  = a[31:9];
    hit = m_valid[s] && (m_tag[s] == tg);
    step();
    n = 0;
    while (!pc_ready && n < 200) begin step(); n++; end
    if (!pc_ready) begin chk("pc_ready_timeout", 0, 1); return; end
    v_pc = 1'b1; pc = a;
    if (hit) exp_inst.push_back(mem_word({a[31:2], 2'b00}));
    step();
    v_pc = 1'b0;
    @(negedge clk); chk("inst_not_early", {63'b0, v_inst}, 0);
    if (hit) begin
      @(negedge clk);
      chk("hit_latency", {63'b0, v_inst}, 1);
      chk("hit_no_req", {63'b0, v_ic_req}, 0);
      step();
      return;
    end
    n = 0;
    while (!v_ic_req && n < 10) begin step(); n++; end
    if (!v_ic_req) begin chk("req_timeout", 0, 1); return; end
    m = exp_msg(a);
    exp_req.push_back({a[12:11] == 2'b00, m});
    d = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
    repeat (d) begin
      @(negedge clk); chk("req_stable", {16'b0, req_msg}, {16'b0, m});
      step();
    end
    ic_req_ready = 1'b1;
    step();
    ic_req_ready = 1'b0;
    chk("req_sent_once", {63'b0, v_ic_req}, 0);
    repeat ($urandom_range(0, 3)) step();
    if (flush_in_wait) begin flush = 1'b1; step(); flush = 1'b0; end
    for (int k = 0; k < 4; k++) line[32*k +: 32] = mem_word({a[31:4], 4'b0} + 32'(4*k));
    exp_inst.push_back(mem_word({a[31:2], 2'b00}));
    refill_data = line; v_refill = 1'b1;
    step();
    v_refill = 1'b0; refill_data = {$urandom, $urandom, $urandom, $urandom};
    m_valid[s] = 1'b1; m_tag[s] = tg;
    if (flush_in_wait) invalidate_all();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (v_inst) begin
        if (exp_inst.size() == 0) chk("inst_unexpected", 1, 0);
        else chk("inst", {32'b0, inst}, {32'b0, exp_inst.pop_front()});
      end
      if (v_ic_req && ic_req_ready) begin
        if (exp_req.size() == 0) chk("req_unexpected", 1, 0);
        else chk("req_msg", {15'b0, local_or_OUT, req_msg}, {15'b0, exp_req.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    invalidate_all();
    mem[32'h1A00] = 32'h1111; mem[32'h1A04] = 32'h2222;
    mem[32'h1A08] = 32'h3333; mem[32'h1A0C] = 32'h4444;

    // reset state and post-reset sweep length
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_outputs", {pc_ready, v_inst, v_ic_req, local_or_OUT}, 0);
    chk("rst_inst", {32'b0, inst}, 0);
    chk("rst_req_msg", {16'b0, req_msg}, 0);
    step();
    rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (!pc_ready && n < 100) begin
      chk("sweep_quiet", {v_inst, v_ic_req}, 0);
      n++;
      @(negedge clk);
    end
    chk("sweep_len", n, SETS);

    fetch(32'h0000_1A04, 3, 1'b0);   // cold miss, remote home, inst 0x2222
    fetch(32'h0000_1A08, 0, 1'b0);   // hit, inst 0x3333
    fetch(32'h0000_1E04, -1, 1'b0);  // same set, other tag: evicts
    fetch(32'h0000_1A04, -1, 1'b0);  // misses again
    fetch(32'h0000_0004, -1, 1'b0);  // local home

    // refill while idle must not touch the arrays
    step();
    refill_data = {4{32'hDEAD_BEEF}}; v_refill = 1'b1;
    step();
    v_refill = 1'b0;
    fetch(32'h0000_0004, -1, 1'b0);

    // flush during WAIT: word delivered, then one IDLE cycle takes the flush and SETS sweep cycles follow
    fetch(32'h0000_1A04, -1, 1'b1);
    n = 0;
    while (!pc_ready && n < 100) begin step(); n++; end
    chk("flush_sweep_len", n, SETS + 1);
    fetch(32'h0000_1A04, -1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      a = (32'($urandom_range(0, 7)) << 11) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      fetch(a, -1, ($urandom_range(0, 9) == 0));
    end

    repeat (4) step();
    chk("inst_queue_drained", exp_inst.size(), 0);
    chk("req_queue_drained", exp_req.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
